// File: rtl/sa_pkg.sv
// Shared port/select coding for the 5-port switch allocator.
// Optional lock watchdog enabled by defining SA_TIMEOUT_EN.
package sa_pkg;
    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    typedef logic [SEL_W-1:0] port_t;

    localparam port_t PORT_L   = 3'd0;
    localparam port_t PORT_N   = 3'd1;
    localparam port_t PORT_E   = 3'd2;
    localparam port_t PORT_W   = 3'd3;
    localparam port_t PORT_S   = 3'd4;
    localparam port_t SEL_NONE = 3'd0;

    typedef enum logic {OUT_IDLE = 1'b0, OUT_BUSY = 1'b1} out_state_e;

    function automatic port_t port_to_sel(input port_t p);
        return p + port_t'(1);
    endfunction

    function automatic port_t sel_to_port(input port_t s);
        return s - port_t'(1);
    endfunction

    function automatic logic sel_valid(input port_t s);
        return (s != SEL_NONE) && (s <= port_t'(NUM_PORTS));
    endfunction

    function automatic port_t next_port(input port_t p);
        return (p == port_t'(NUM_PORTS - 1)) ? PORT_L : p + port_t'(1);
    endfunction
endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between input buffers, allocator and crossbar.
interface switch_allocator_if;
    import sa_pkg::*;
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS*SEL_W-1:0] dst;
    logic [NUM_PORTS-1:0]       tail;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       grant;
    logic [NUM_PORTS-1:0]       xfer;
    logic [SEL_W-1:0]           S_L, S_N, S_E, S_W, S_S;
    logic                       dst_err;

    modport master (output req, dst, tail, out_ready,
                    input  grant, xfer, S_L, S_N, S_E, S_W, S_S, dst_err);
    modport slave  (input  req, dst, tail, out_ready,
                    output grant, xfer, S_L, S_N, S_E, S_W, S_S, dst_err);
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational 5-way round-robin pick: first request at or after ptr.
module rr_arbiter
    import sa_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_t                ptr,
    output logic                 vld,
    output port_t                winner
);
    logic [SEL_W:0] sum;

    always_comb begin
        vld    = |req;
        winner = PORT_L;
        sum    = '0;
        // Scan farthest-first so the closest request to ptr is written last.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(NUM_PORTS)) sum = sum - (SEL_W + 1)'(NUM_PORTS);
            if (req[sum[SEL_W-1:0]]) winner = sum[SEL_W-1:0];
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin allocator with packet locking for the 5-port router.
// Define SA_TIMEOUT_EN to add a per-output lock watchdog.
module switch_allocator
    import sa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  bus
);
    logic [NUM_PORTS-1:0][SEL_W-1:0]     dst_code;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0][SEL_W-1:0]     owner, sel, winner;
    logic [NUM_PORTS-1:0] win_vld, busy, out_xfer, rel_out;
    logic [NUM_PORTS-1:0] grant_q, grant_set, grant_clr, xfer, bad_dst;
    logic                 dst_err_q;

    assign dst_code = bus.dst;

    // An input already holding a lock never competes for a second output.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++)
            for (int i = 0; i < NUM_PORTS; i++)
                cand[o][i] = bus.req[i] & ~grant_q[i] & (dst_code[i] == port_to_sel(port_t'(o)));
        for (int i = 0; i < NUM_PORTS; i++)
            bad_dst[i] = bus.req[i] & ~sel_valid(dst_code[i]);
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        out_state_e st;
        port_t      own, ptr, sel_q;
        logic       rel;

        rr_arbiter u_arb (.req(cand[o]), .ptr(ptr), .vld(win_vld[o]), .winner(winner[o]));

        assign busy[o]     = (st == OUT_BUSY);
        assign out_xfer[o] = busy[o] & bus.req[own] & bus.out_ready[o];

`ifdef SA_TIMEOUT_EN
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                  cnt <= '0;
            else if (!busy[o] || out_xfer[o] || rel)  cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);
        end
        assign rel = (out_xfer[o] & bus.tail[own]) |
                     (busy[o] & ~out_xfer[o] & (cnt == CNT_W'(TIMEOUT - 1)));
`else
        assign rel = out_xfer[o] & bus.tail[own];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st    <= OUT_IDLE;
                own   <= PORT_L;
                ptr   <= PORT_L;
                sel_q <= SEL_NONE;
            end else begin
                case (st)
                    OUT_IDLE: if (win_vld[o]) begin
                        st    <= OUT_BUSY;
                        own   <= winner[o];
                        sel_q <= port_to_sel(winner[o]);
                    end
                    OUT_BUSY: if (rel) begin
                        st    <= OUT_IDLE;
                        sel_q <= SEL_NONE;
                        ptr   <= next_port(own);
                    end
                    default: st <= OUT_IDLE;
                endcase
            end
        end

        assign owner[o]   = own;
        assign sel[o]     = sel_q;
        assign rel_out[o] = rel;
    end

    always_comb begin
        grant_set = '0;
        grant_clr = '0;
        xfer      = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (!busy[o] && win_vld[o]) grant_set[winner[o]] = 1'b1;
            if (rel_out[o])             grant_clr[owner[o]]  = 1'b1;
            if (out_xfer[o])            xfer[owner[o]]       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            dst_err_q <= 1'b0;
        end else begin
            grant_q   <= (grant_q & ~grant_clr) | grant_set;
            dst_err_q <= |bad_dst;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.xfer    = xfer;
    assign bus.dst_err = dst_err_q;
    assign bus.S_L     = sel[PORT_L];
    assign bus.S_N     = sel[PORT_N];
    assign bus.S_E     = sel[PORT_E];
    assign bus.S_W     = sel[PORT_W];
    assign bus.S_S     = sel[PORT_S];
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator; SA_TIMEOUT_EN selects the watchdog scenario.
module tb_switch_allocator;
    import sa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    switch_allocator_if bus ();
    switch_allocator dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dst(input int i, input logic [2:0] c);
        bus.dst[3*i +: 3] = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.dst = '0; bus.tail = '0; bus.out_ready = 5'h1f;
        #1;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_SL", 32'(bus.S_L), 0);
        chk("rst_SN", 32'(bus.S_N), 0);
        chk("rst_SE", 32'(bus.S_E), 0);
        chk("rst_SW", 32'(bus.S_W), 0);
        chk("rst_SS", 32'(bus.S_S), 0);
        chk("rst_dst_err", 32'(bus.dst_err), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Contention: N, E, W all to L, 3-flit packets
        bus.req = 5'b01110; set_dst(1, 3'd1); set_dst(2, 3'd1); set_dst(3, 3'd1);
        #1;
        chk("cont_t0_grant", 32'(bus.grant), 0);
        tick();
        chk("cont_N_grant", 32'(bus.grant), 32'b00010);
        chk("cont_N_SL", 32'(bus.S_L), 2);
        chk("cont_N_xfer", 32'(bus.xfer), 32'b00010);
        tick();
        chk("cont_N_hold", 32'(bus.grant), 32'b00010);
        tick();
        bus.tail = 5'b00010; #1;
        chk("cont_N_tail_xfer", 32'(bus.xfer), 32'b00010);
        tick();
        bus.req = 5'b01100; bus.tail = '0; #1;
        chk("cont_bubble1_SL", 32'(bus.S_L), 0);
        chk("cont_bubble1_grant", 32'(bus.grant), 0);
        chk("cont_bubble1_xfer", 32'(bus.xfer), 0);
        tick();
        chk("cont_E_SL", 32'(bus.S_L), 3);
        chk("cont_E_grant", 32'(bus.grant), 32'b00100);
        tick(); tick();
        bus.tail = 5'b00100; #1;
        chk("cont_E_tail_xfer", 32'(bus.xfer), 32'b00100);
        tick();
        bus.req = 5'b01000; bus.tail = '0; #1;
        chk("cont_bubble2_SL", 32'(bus.S_L), 0);
        tick();
        chk("cont_W_SL", 32'(bus.S_L), 4);
        chk("cont_W_grant", 32'(bus.grant), 32'b01000);
        tick(); tick();
        bus.tail = 5'b01000;
        tick();
        bus.req = '0; bus.tail = '0; #1;
        chk("cont_done_SL", 32'(bus.S_L), 0);
        chk("cont_done_grant", 32'(bus.grant), 0);

        // Parallel: L->E, N->S, W->N
        set_dst(0, 3'd3); set_dst(1, 3'd5); set_dst(3, 3'd2);
        bus.req = 5'b01011;
        tick();
        chk("par_grant", 32'(bus.grant), 32'b01011);
        chk("par_SE", 32'(bus.S_E), 1);
        chk("par_SS", 32'(bus.S_S), 2);
        chk("par_SN", 32'(bus.S_N), 4);
        chk("par_SL", 32'(bus.S_L), 0);
        bus.tail = 5'b01011; #1;
        chk("par_xfer", 32'(bus.xfer), 32'b01011);
        tick();
        bus.req = '0; bus.tail = '0; #1;
        chk("par_done_grant", 32'(bus.grant), 0);
        chk("par_done_SE", 32'(bus.S_E), 0);

        // Stall: E->W with out_ready[W]=0, S also waiting for W
        set_dst(2, 3'd4); set_dst(4, 3'd4);
        bus.req = 5'b00100;
        tick();
        chk("stall_grant", 32'(bus.grant), 32'b00100);
        chk("stall_SW", 32'(bus.S_W), 3);
        chk("stall_head_xfer", 32'(bus.xfer), 32'b00100);
        bus.req = 5'b10100; bus.out_ready = 5'b10111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold_grant", 32'(bus.grant), 32'b00100);
            chk("stall_hold_xfer", 32'(bus.xfer), 0);
            chk("stall_hold_SW", 32'(bus.S_W), 3);
        end
        tick();
        bus.out_ready = 5'h1f; bus.req = 5'b10000; #1;
        chk("drop_req_xfer", 32'(bus.xfer), 0);
        chk("drop_req_grant", 32'(bus.grant), 32'b00100);
        tick();
        bus.req = 5'b10100; bus.tail = 5'b00100; #1;
        chk("stall_resume_xfer", 32'(bus.xfer), 32'b00100);
        tick();
        bus.req = 5'b10000; bus.tail = '0; #1;
        chk("stall_bubble_SW", 32'(bus.S_W), 0);
        chk("stall_bubble_grant", 32'(bus.grant), 0);

        // Single-flit packet from S to W
        tick();
        chk("single_grant", 32'(bus.grant), 32'b10000);
        chk("single_SW", 32'(bus.S_W), 5);
        bus.tail = 5'b10000; #1;
        chk("single_xfer", 32'(bus.xfer), 32'b10000);
        tick();
        bus.req = '0; bus.tail = '0; #1;
        chk("single_after_grant", 32'(bus.grant), 0);
        chk("single_after_SW", 32'(bus.S_W), 0);

        // Invalid destination
        set_dst(0, 3'd7); bus.req = 5'b00001; #1;
        chk("bad_dst_t0", 32'(bus.dst_err), 0);
        tick();
        bus.req = '0; #1;
        chk("bad_dst_pulse", 32'(bus.dst_err), 1);
        chk("bad_dst_grant", 32'(bus.grant), 0);
        tick();
        chk("bad_dst_clear", 32'(bus.dst_err), 0);

        // Owner stops after head flit; W waits for E
        set_dst(1, 3'd3); set_dst(3, 3'd3); bus.req = 5'b00010;
        tick();
        chk("lock_grant", 32'(bus.grant), 32'b00010);
        chk("lock_SE", 32'(bus.S_E), 2);
        chk("lock_head_xfer", 32'(bus.xfer), 32'b00010);
        tick();
        bus.req = 5'b01000;
`ifdef SA_TIMEOUT_EN
        for (int k = 0; k < 15; k++) tick();
        chk("to_before_grant", 32'(bus.grant), 32'b00010);
        tick();
        chk("to_freed_grant", 32'(bus.grant), 0);
        chk("to_freed_SE", 32'(bus.S_E), 0);
        tick();
        chk("to_next_grant", 32'(bus.grant), 32'b01000);
        chk("to_next_SE", 32'(bus.S_E), 4);
`else
        for (int k = 0; k < 20; k++) tick();
        chk("nolock_to_grant", 32'(bus.grant), 32'b00010);
        chk("nolock_to_SE", 32'(bus.S_E), 2);
`endif

        // Reset mid-packet drops every lock immediately
        bus.req = 5'b01010;
        rst = 1'b1; #1;
        chk("midrst_grant", 32'(bus.grant), 0);
        chk("midrst_SE", 32'(bus.S_E), 0);
        chk("midrst_xfer", 32'(bus.xfer), 0);
        tick();
        bus.req = '0;
        rst = 1'b0;
        tick();
        chk("post_rst_grant", 32'(bus.grant), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
